// File: rtl/calc_pkg.sv
// Shared definitions for the BCD calculator: key codes, ALU opcodes, control states
// and the default operand width. The ALU imports the same opcode enum.
package calc_pkg;

   localparam int DIGIT_NUM_DEFAULT = 8;

   localparam logic [4:0] KEY_DIGIT_MAX = 5'd9;
   localparam logic [4:0] KEY_SUM       = 5'd10;
   localparam logic [4:0] KEY_SUB       = 5'd11;
   localparam logic [4:0] KEY_MUL       = 5'd12;
   localparam logic [4:0] KEY_DIV       = 5'd13;
   localparam logic [4:0] KEY_EXP       = 5'd14;
   localparam logic [4:0] KEY_EQUALS    = 5'd15;
   localparam logic [4:0] KEY_SIGN      = 5'd16;
   localparam logic [4:0] KEY_CLEAR     = 5'd17;

   typedef enum logic [2:0] {
      OP_SUM = 3'b000,
      OP_SUB = 3'b001,
      OP_MUL = 3'b010,
      OP_DIV = 3'b011,
      OP_EXP = 3'b100
   } alu_op_e;

   typedef enum logic [2:0] {
      ST_ENTER_A = 3'd0,
      ST_ENTER_B = 3'd1,
      ST_EXEC    = 3'd2,
      ST_SHOW    = 3'd3,
      ST_ERROR   = 3'd4
   } calc_state_e;

   function automatic logic isDigitKey(input logic [4:0] code);
      return code <= KEY_DIGIT_MAX;
   endfunction

   function automatic logic isOperatorKey(input logic [4:0] code);
      return (code >= KEY_SUM) && (code <= KEY_EXP);
   endfunction

   function automatic alu_op_e keyToOp(input logic [4:0] code);
      alu_op_e op;
      case (code)
         KEY_SUB: op = OP_SUB;
         KEY_MUL: op = OP_MUL;
         KEY_DIV: op = OP_DIV;
         KEY_EXP: op = OP_EXP;
         default: op = OP_SUM;
      endcase
      return op;
   endfunction

endpackage

// File: rtl/bcd_entry_reg.sv
// One sign-magnitude BCD operand being typed in: digit shift register with a digit
// counter, sign toggle, clear and parallel load (used for result chaining).
module bcd_entry_reg
   import calc_pkg::*;
#(
   parameter int DIGIT_NUM = DIGIT_NUM_DEFAULT
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   clear_i,
   input  logic                   digitValid_i,
   input  logic [3:0]             digit_i,
   input  logic                   signToggle_i,
   input  logic                   load_i,
   input  logic [4*DIGIT_NUM-1:0] loadValue_i,
   input  logic                   loadSign_i,
   output logic [4*DIGIT_NUM-1:0] value_o,
   output logic                   sign_o,
   output logic                   empty_o
);

   localparam int CW = $clog2(DIGIT_NUM + 1);

   logic [4*DIGIT_NUM-1:0] value_q, value_d;
   logic                   sign_q, sign_d;
   logic [CW-1:0]          count_q, count_d;

   // Clear and load are applied first so a digit in the same cycle lands on the fresh value.
   always_comb begin
      value_d = value_q;
      sign_d  = sign_q;
      count_d = count_q;
      if (clear_i) begin
         value_d = '0;
         sign_d  = 1'b0;
         count_d = '0;
      end
      if (load_i) begin
         value_d = loadValue_i;
         sign_d  = loadSign_i;
         count_d = CW'(DIGIT_NUM);
      end
      if (digitValid_i && (count_d < CW'(DIGIT_NUM)) &&
          !((count_d == '0) && (digit_i == 4'd0))) begin
         value_d = {value_d[4*DIGIT_NUM-5:0], digit_i};
         count_d = count_d + CW'(1);
      end
      if (signToggle_i) begin
         sign_d = ~sign_d;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         value_q <= '0;
         sign_q  <= 1'b0;
         count_q <= '0;
      end else begin
         value_q <= value_d;
         sign_q  <= sign_d;
         count_q <= count_d;
      end
   end

   assign value_o = value_q;
   assign sign_o  = sign_q;
   assign empty_o = (count_q == '0);

endmodule

// File: rtl/calc_entry_ctrl.sv
// Keypad-side control of the BCD calculator: builds two operands from key presses,
// dispatches them to the combinational ALU, captures its result and drives the display.
module calc_entry_ctrl
   import calc_pkg::*;
#(
   parameter int DIGIT_NUM = DIGIT_NUM_DEFAULT
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   key_valid,
   input  logic [4:0]             key_code,
   input  logic [4*DIGIT_NUM-1:0] alu_result,
   input  logic                   alu_flag_ov,
   input  logic                   alu_flag_sign,
   output logic [4*DIGIT_NUM-1:0] operand0,
   output logic [4*DIGIT_NUM-1:0] operand1,
   output logic                   operand0_sign,
   output logic                   operand1_sign,
   output logic [2:0]             operation,
   output logic [4*DIGIT_NUM-1:0] disp_value,
   output logic                   disp_sign,
   output logic                   busy,
   output logic                   error
);

   calc_state_e            state_q, state_d;
   alu_op_e                operation_q, operation_d;
   logic [4*DIGIT_NUM-1:0] result_q, result_d;
   logic                   resultSign_q, resultSign_d;
   logic                   busy_q, error_q;

   logic aClear, aDigit, aSignToggle, aLoad;
   logic bClear, bDigit, bSignToggle;
   logic emptyB, unusedEmptyA;
   logic isDigit, isOperator, isEquals, isSign, isClear;

   always_comb begin
      isDigit    = key_valid && isDigitKey(key_code);
      isOperator = key_valid && isOperatorKey(key_code);
      isEquals   = key_valid && (key_code == KEY_EQUALS);
      isSign     = key_valid && (key_code == KEY_SIGN);
      isClear    = key_valid && (key_code == KEY_CLEAR);
   end

   // Next-state and operand-control decode; EXEC ignores every key, CLEAR included.
   always_comb begin
      state_d      = state_q;
      operation_d  = operation_q;
      result_d     = result_q;
      resultSign_d = resultSign_q;
      aClear       = 1'b0;
      aDigit       = 1'b0;
      aSignToggle  = 1'b0;
      aLoad        = 1'b0;
      bClear       = 1'b0;
      bDigit       = 1'b0;
      bSignToggle  = 1'b0;
      case (state_q)
         ST_ENTER_A: begin
            if (isDigit) begin
               aDigit = 1'b1;
            end else if (isOperator) begin
               operation_d = keyToOp(key_code);
               bClear      = 1'b1;
               state_d     = ST_ENTER_B;
            end else if (isSign) begin
               aSignToggle = 1'b1;
            end
         end
         ST_ENTER_B: begin
            if (isDigit) begin
               bDigit = 1'b1;
            end else if (isOperator) begin
               if (emptyB) begin
                  operation_d = keyToOp(key_code);
               end
            end else if (isSign) begin
               bSignToggle = 1'b1;
            end else if (isEquals) begin
               state_d = ST_EXEC;
            end
         end
         ST_EXEC: begin
            result_d     = alu_result;
            resultSign_d = alu_flag_sign && (alu_result != '0);
            state_d      = alu_flag_ov ? ST_ERROR : ST_SHOW;
         end
         ST_SHOW: begin
            if (isDigit) begin
               aClear  = 1'b1;
               aDigit  = 1'b1;
               state_d = ST_ENTER_A;
            end else if (isOperator) begin
               aLoad       = 1'b1;
               operation_d = keyToOp(key_code);
               bClear      = 1'b1;
               state_d     = ST_ENTER_B;
            end else if (isSign) begin
               if (result_q != '0) begin
                  resultSign_d = ~resultSign_q;
               end
            end
         end
         ST_ERROR: begin
         end
         default: begin
            state_d = ST_ENTER_A;
         end
      endcase
      if (isClear && (state_q != ST_EXEC)) begin
         aClear       = 1'b1;
         bClear       = 1'b1;
         operation_d  = OP_SUM;
         result_d     = '0;
         resultSign_d = 1'b0;
         state_d      = ST_ENTER_A;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= ST_ENTER_A;
         operation_q  <= OP_SUM;
         result_q     <= '0;
         resultSign_q <= 1'b0;
         busy_q       <= 1'b0;
         error_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         operation_q  <= operation_d;
         result_q     <= result_d;
         resultSign_q <= resultSign_d;
         busy_q       <= (state_d == ST_EXEC);
         error_q      <= (state_d == ST_ERROR);
      end
   end

   bcd_entry_reg #(.DIGIT_NUM(DIGIT_NUM)) entryA (
      .clk          (clk),
      .reset        (reset),
      .clear_i      (aClear),
      .digitValid_i (aDigit),
      .digit_i      (key_code[3:0]),
      .signToggle_i (aSignToggle),
      .load_i       (aLoad),
      .loadValue_i  (result_q),
      .loadSign_i   (resultSign_q),
      .value_o      (operand0),
      .sign_o       (operand0_sign),
      .empty_o      (unusedEmptyA)
   );

   bcd_entry_reg #(.DIGIT_NUM(DIGIT_NUM)) entryB (
      .clk          (clk),
      .reset        (reset),
      .clear_i      (bClear),
      .digitValid_i (bDigit),
      .digit_i      (key_code[3:0]),
      .signToggle_i (bSignToggle),
      .load_i       (1'b0),
      .loadValue_i  ('0),
      .loadSign_i   (1'b0),
      .value_o      (operand1),
      .sign_o       (operand1_sign),
      .empty_o      (emptyB)
   );

   // The display follows whichever register the current state is about.
   always_comb begin
      disp_value = '0;
      disp_sign  = 1'b0;
      case (state_q)
         ST_ENTER_A: begin
            disp_value = operand0;
            disp_sign  = operand0_sign;
         end
         ST_ENTER_B: begin
            disp_value = operand1;
            disp_sign  = operand1_sign;
         end
         ST_EXEC, ST_SHOW: begin
            disp_value = result_q;
            disp_sign  = resultSign_q;
         end
         default: begin
            disp_value = '0;
            disp_sign  = 1'b0;
         end
      endcase
   end

   assign operation = operation_q;
   assign busy      = busy_q;
   assign error     = error_q;

endmodule

// File: tb/tb_calc_entry_ctrl.sv
// Self-checking bench for calc_entry_ctrl: directed vector table, hand-written corner
// sequences, then random keys compared against an integer-level reference model.
module tb_calc_entry_ctrl;

   localparam int N = 8;
   localparam int W = 4 * N;
   localparam longint LIMIT = 64'd99999999;

   localparam int MODE_A    = 0;
   localparam int MODE_B    = 1;
   localparam int MODE_CALC = 2;
   localparam int MODE_SHOW = 3;
   localparam int MODE_ERR  = 4;

   typedef struct packed {
      logic [W-1:0] op0;
      logic [W-1:0] op1;
      logic         s0;
      logic         s1;
      logic [2:0]   opn;
      logic [W-1:0] disp;
      logic         ds;
      logic         busy;
      logic         err;
   } outs_t;

   typedef struct {
      logic       kv;
      logic [4:0] code;
      outs_t      exp;
   } vec_t;

   logic         clk = 1'b0;
   logic         reset;
   logic         key_valid;
   logic [4:0]   key_code;
   logic [W-1:0] alu_result;
   logic         alu_flag_ov;
   logic         alu_flag_sign;
   logic [W-1:0] operand0, operand1, disp_value;
   logic         operand0_sign, operand1_sign, disp_sign, busy, error;
   logic [2:0]   operation;

   int checks = 0;
   int errors = 0;

   longint mMag0, mMag1, mRes;
   logic   mSgn0, mSgn1, mResSgn;
   int     mCnt0, mCnt1, mOpn, mMode;

   longint aluMag, mCalcMag;
   logic   aluNeg, aluOv, mCalcNeg, mCalcOv;

   vec_t vecs[26];

   always #5 clk = ~clk;

   calc_entry_ctrl #(.DIGIT_NUM(N)) dut (
      .clk           (clk),
      .reset         (reset),
      .key_valid     (key_valid),
      .key_code      (key_code),
      .alu_result    (alu_result),
      .alu_flag_ov   (alu_flag_ov),
      .alu_flag_sign (alu_flag_sign),
      .operand0      (operand0),
      .operand1      (operand1),
      .operand0_sign (operand0_sign),
      .operand1_sign (operand1_sign),
      .operation     (operation),
      .disp_value    (disp_value),
      .disp_sign     (disp_sign),
      .busy          (busy),
      .error         (error)
   );

   function automatic longint bcdToInt(input logic [W-1:0] v);
      longint r = 0;
      for (int i = N - 1; i >= 0; i--) r = r * 10 + longint'(v[i*4 +: 4]);
      return r;
   endfunction

   function automatic logic [W-1:0] intToBcd(input longint v);
      logic [W-1:0] r = '0;
      longint t = v;
      for (int i = 0; i < N; i++) begin
         r[i*4 +: 4] = 4'(t % 10);
         t = t / 10;
      end
      return r;
   endfunction

   // Behavioural signed-decimal ALU shared by the bench's ALU stand-in and the model.
   function automatic void aluRef(input longint ma, input logic sa, input longint mb,
                                  input logic sb, input int opn,
                                  output longint mag, output logic neg, output logic ov);
      longint a = sa ? -ma : ma;
      longint b = sb ? -mb : mb;
      longint r = 0;
      ov  = 1'b0;
      neg = 1'b0;
      case (opn)
         0: begin r = a + b; neg = (r < 0); end
         1: begin r = a - b; neg = (r < 0); end
         2: begin r = a * b; neg = sa ^ sb; end
         3: begin
            if (b == 0) ov = 1'b1;
            else r = a / b;
            neg = sa ^ sb;
         end
         default: begin
            if (b < 0) ov = 1'b1;
            else if (a == 0) r = (b == 0) ? 1 : 0;
            else if (a == 1) r = 1;
            else if (a == -1) r = (b % 2 == 0) ? 1 : -1;
            else begin
               r = 1;
               for (longint i = 0; i < b; i++) begin
                  r = r * a;
                  if (r > LIMIT || r < -LIMIT) break;
               end
            end
            neg = (r < 0);
         end
      endcase
      mag = (r < 0) ? -r : r;
      if (mag > LIMIT) ov = 1'b1;
   endfunction

   always_comb begin
      aluMag = 0;
      aluNeg = 1'b0;
      aluOv  = 1'b0;
      aluRef(bcdToInt(operand0), operand0_sign, bcdToInt(operand1), operand1_sign,
             int'(operation), aluMag, aluNeg, aluOv);
      alu_result    = intToBcd(aluMag % 100000000);
      alu_flag_sign = aluNeg;
      alu_flag_ov   = aluOv;
   end

   task automatic modelReset();
      mMag0 = 0; mMag1 = 0; mRes = 0;
      mSgn0 = 0; mSgn1 = 0; mResSgn = 0;
      mCnt0 = 0; mCnt1 = 0; mOpn = 0; mMode = MODE_A;
   endtask

   task automatic typeDigit(inout longint mag, inout int cnt, input int d);
      if (cnt < N && !(cnt == 0 && d == 0)) begin
         mag = mag * 10 + d;
         cnt++;
      end
   endtask

   task automatic startOperandB(input int code);
      mOpn  = code - 10;
      mMag1 = 0; mSgn1 = 0; mCnt1 = 0;
      mMode = MODE_B;
   endtask

   task automatic modelKey(input int code);
      bit isDig = (code <= 9);
      bit isOpr = (code >= 10 && code <= 14);
      if (code == 17) begin
         modelReset();
         return;
      end
      case (mMode)
         MODE_A: begin
            if (isDig) typeDigit(mMag0, mCnt0, code);
            else if (isOpr) startOperandB(code);
            else if (code == 16) mSgn0 = ~mSgn0;
         end
         MODE_B: begin
            if (isDig) typeDigit(mMag1, mCnt1, code);
            else if (isOpr && mCnt1 == 0) mOpn = code - 10;
            else if (code == 16) mSgn1 = ~mSgn1;
            else if (code == 15) mMode = MODE_CALC;
         end
         MODE_SHOW: begin
            if (isDig) begin
               mMag0 = 0; mSgn0 = 0; mCnt0 = 0;
               typeDigit(mMag0, mCnt0, code);
               mMode = MODE_A;
            end else if (isOpr) begin
               mMag0 = mRes; mSgn0 = mResSgn; mCnt0 = N;
               startOperandB(code);
            end else if (code == 16 && mRes != 0) begin
               mResSgn = ~mResSgn;
            end
         end
         default: ;
      endcase
   endtask

   task automatic modelStep();
      if (mMode == MODE_CALC) begin
         aluRef(mMag0, mSgn0, mMag1, mSgn1, mOpn, mCalcMag, mCalcNeg, mCalcOv);
         mRes    = mCalcMag;
         mResSgn = mCalcNeg && (mCalcMag != 0);
         mMode   = mCalcOv ? MODE_ERR : MODE_SHOW;
      end else if (key_valid) begin
         modelKey(int'(key_code));
      end
   endtask

   function automatic outs_t mkOuts(input logic [W-1:0] op0, input logic [W-1:0] op1,
                                    input logic s0, input logic s1, input logic [2:0] opn,
                                    input logic [W-1:0] disp, input logic ds,
                                    input logic bsy, input logic err);
      outs_t o;
      o.op0 = op0; o.op1 = op1; o.s0 = s0; o.s1 = s1; o.opn = opn;
      o.disp = disp; o.ds = ds; o.busy = bsy; o.err = err;
      return o;
   endfunction

   function automatic vec_t mk(input logic kv, input logic [4:0] code,
                               input logic [W-1:0] op0, input logic [W-1:0] op1,
                               input logic [2:0] opn, input logic [W-1:0] disp,
                               input logic ds, input logic bsy);
      vec_t v;
      v.kv   = kv;
      v.code = code;
      v.exp  = mkOuts(op0, op1, 1'b0, 1'b0, opn, disp, ds, bsy, 1'b0);
      return v;
   endfunction

   function automatic outs_t modelExpected();
      outs_t e;
      e = mkOuts(intToBcd(mMag0), intToBcd(mMag1), mSgn0, mSgn1, 3'(mOpn), '0, 1'b0,
                 mMode == MODE_CALC, mMode == MODE_ERR);
      case (mMode)
         MODE_A: begin e.disp = intToBcd(mMag0); e.ds = mSgn0; end
         MODE_B: begin e.disp = intToBcd(mMag1); e.ds = mSgn1; end
         MODE_CALC, MODE_SHOW: begin e.disp = intToBcd(mRes); e.ds = mResSgn; end
         default: ;
      endcase
      return e;
   endfunction

   function automatic outs_t dutOuts();
      return mkOuts(operand0, operand1, operand0_sign, operand1_sign, operation,
                    disp_value, disp_sign, busy, error);
   endfunction

   task automatic checkOutput(input string name, input outs_t exp);
      outs_t act = dutOuts();
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got op0=%h op1=%h s0=%b s1=%b opn=%0d disp=%h ds=%b busy=%b err=%b; want op0=%h op1=%h s0=%b s1=%b opn=%0d disp=%h ds=%b busy=%b err=%b",
                  name, act.op0, act.op1, act.s0, act.s1, act.opn, act.disp, act.ds,
                  act.busy, act.err, exp.op0, exp.op1, exp.s0, exp.s1, exp.opn,
                  exp.disp, exp.ds, exp.busy, exp.err);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      if (reset) modelReset();
      else modelStep();
      #1;
   endtask

   task automatic applyStimulus(input logic kv, input logic [4:0] code);
      key_valid = kv;
      key_code  = code;
      tick();
      key_valid = 1'b0;
   endtask

   initial begin
      int unsigned r;
      reset     = 1'b1;
      key_valid = 1'b0;
      key_code  = '0;
      modelReset();

      vecs[0]  = mk(1, 1,  'h1,   'h0,  0, 'h1,   0, 0);
      vecs[1]  = mk(1, 2,  'h12,  'h0,  0, 'h12,  0, 0);
      vecs[2]  = mk(1, 3,  'h123, 'h0,  0, 'h123, 0, 0);
      vecs[3]  = mk(1, 10, 'h123, 'h0,  0, 'h0,   0, 0);
      vecs[4]  = mk(1, 4,  'h123, 'h4,  0, 'h4,   0, 0);
      vecs[5]  = mk(1, 5,  'h123, 'h45, 0, 'h45,  0, 0);
      vecs[6]  = mk(1, 15, 'h123, 'h45, 0, 'h0,   0, 1);
      vecs[7]  = mk(0, 0,  'h123, 'h45, 0, 'h168, 0, 0);
      vecs[8]  = mk(1, 20, 'h123, 'h45, 0, 'h168, 0, 0);
      vecs[9]  = mk(1, 5,  'h5,   'h45, 0, 'h5,   0, 0);
      vecs[10] = mk(1, 11, 'h5,   'h0,  1, 'h0,   0, 0);
      vecs[11] = mk(1, 8,  'h5,   'h8,  1, 'h8,   0, 0);
      vecs[12] = mk(1, 15, 'h5,   'h8,  1, 'h168, 0, 1);
      vecs[13] = mk(0, 0,  'h5,   'h8,  1, 'h3,   1, 0);
      vecs[14] = mk(1, 16, 'h5,   'h8,  1, 'h3,   0, 0);
      vecs[15] = mk(1, 17, 'h0,   'h0,  0, 'h0,   0, 0);
      vecs[16] = mk(1, 7,  'h7,   'h0,  0, 'h7,   0, 0);
      vecs[17] = mk(1, 10, 'h7,   'h0,  0, 'h0,   0, 0);
      vecs[18] = mk(1, 3,  'h7,   'h3,  0, 'h3,   0, 0);
      vecs[19] = mk(1, 15, 'h7,   'h3,  0, 'h0,   0, 1);
      vecs[20] = mk(0, 0,  'h7,   'h3,  0, 'h10,  0, 0);
      vecs[21] = mk(1, 11, 'h10,  'h0,  1, 'h0,   0, 0);
      vecs[22] = mk(1, 4,  'h10,  'h4,  1, 'h4,   0, 0);
      vecs[23] = mk(1, 15, 'h10,  'h4,  1, 'h10,  0, 1);
      vecs[24] = mk(0, 0,  'h10,  'h4,  1, 'h6,   0, 0);
      vecs[25] = mk(1, 20, 'h10,  'h4,  1, 'h6,   0, 0);

      tick();
      tick();
      checkOutput("reset state", '0);
      reset = 1'b0;

      for (int i = 0; i < 26; i++) begin
         applyStimulus(vecs[i].kv, vecs[i].code);
         checkOutput($sformatf("vec%0d", i), vecs[i].exp);
      end

      // Digit-count limit and ignored EQUALS while typing the first operand.
      applyStimulus(1, 17);
      for (int d = 1; d <= 9; d++) applyStimulus(1, 5'(d));
      checkOutput("digit limit", mkOuts('h12345678, 0, 0, 0, 0, 'h12345678, 0, 0, 0));
      applyStimulus(1, 15);
      checkOutput("equals in A", mkOuts('h12345678, 0, 0, 0, 0, 'h12345678, 0, 0, 0));

      applyStimulus(1, 17);
      applyStimulus(1, 0);
      applyStimulus(1, 0);
      applyStimulus(1, 5);
      checkOutput("leading zero", mkOuts('h5, 0, 0, 0, 0, 'h5, 0, 0, 0));

      // Overflow into ERROR, lock-out, then CLEAR.
      applyStimulus(1, 17);
      for (int d = 0; d < 8; d++) applyStimulus(1, 9);
      applyStimulus(1, 10);
      applyStimulus(1, 1);
      applyStimulus(1, 15);
      checkOutput("ov exec", mkOuts('h99999999, 'h1, 0, 0, 0, 0, 0, 1, 0));
      applyStimulus(0, 0);
      checkOutput("ov error", mkOuts('h99999999, 'h1, 0, 0, 0, 0, 0, 0, 1));
      applyStimulus(1, 5);
      checkOutput("error digit", mkOuts('h99999999, 'h1, 0, 0, 0, 0, 0, 0, 1));
      applyStimulus(1, 20);
      checkOutput("error code20", mkOuts('h99999999, 'h1, 0, 0, 0, 0, 0, 0, 1));
      applyStimulus(1, 16);
      checkOutput("error sign", mkOuts('h99999999, 'h1, 0, 0, 0, 0, 0, 0, 1));
      applyStimulus(1, 17);
      checkOutput("error clear", '0);

      // A CLEAR arriving during EXEC is lost.
      applyStimulus(1, 2);
      applyStimulus(1, 10);
      applyStimulus(1, 3);
      applyStimulus(1, 15);
      checkOutput("keyloss exec", mkOuts('h2, 'h3, 0, 0, 0, 0, 0, 1, 0));
      applyStimulus(1, 17);
      checkOutput("keyloss show", mkOuts('h2, 'h3, 0, 0, 0, 'h5, 0, 0, 0));

      // A zero result reported negative by the ALU displays as +0 and cannot be negated.
      applyStimulus(1, 17);
      applyStimulus(1, 5);
      applyStimulus(1, 16);
      applyStimulus(1, 12);
      applyStimulus(1, 0);
      applyStimulus(1, 15);
      applyStimulus(0, 0);
      checkOutput("zero sign", mkOuts('h5, 0, 1, 0, 2, 0, 0, 0, 0));
      applyStimulus(1, 16);
      checkOutput("sign on zero", mkOuts('h5, 0, 1, 0, 2, 0, 0, 0, 0));

      // Reset pulsed between clock edges.
      applyStimulus(1, 17);
      applyStimulus(1, 4);
      applyStimulus(1, 5);
      checkOutput("before reset", mkOuts('h45, 0, 0, 0, 0, 'h45, 0, 0, 0));
      #2;
      reset = 1'b1;
      modelReset();
      #1;
      checkOutput("async reset", '0);
      #1;
      reset = 1'b0;

      for (int n = 0; n < 4000; n++) begin
         r = $urandom_range(0, 99);
         if (r < 50)      applyStimulus(1, 5'($urandom_range(0, 9)));
         else if (r < 62) applyStimulus(1, 5'($urandom_range(10, 14)));
         else if (r < 70) applyStimulus(1, 15);
         else if (r < 77) applyStimulus(1, 16);
         else if (r < 80) applyStimulus(1, 17);
         else if (r < 87) applyStimulus(1, 5'($urandom_range(18, 31)));
         else             applyStimulus(0, 5'($urandom_range(0, 31)));
         checkOutput("random", modelExpected());
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/calc_entry_ctrl.md
# calc_entry_ctrl

Keypad-side control stage of the BCD calculator, directly upstream of the `alu`. It assembles two sign-magnitude BCD operands digit by digit from decoded key presses, latches the requested operation, and presents operands and opcode to the combinational ALU. It captures the ALU result and flags, and drives the value and sign the display stage must show, including result chaining and overflow lock-out.

## Interface
- `DIGIT_NUM`, 8, number of BCD digits per operand; must match the ALU.
- `clk` in 1: single clock; all state changes on the rising edge.
- `reset` in 1: asynchronous, active-high; clears all state.
- `key_valid` in 1: one-cycle strobe, `key_code` valid.
- `key_code` in 5: 0–9 digit, 10 SUM, 11 SUB, 12 MUL, 13 DIV, 14 EXP, 15 EQUALS, 16 SIGN, 17 CLEAR; 18–31 ignored.
- `alu_result` in 4*DIGIT_NUM: ALU magnitude output.
- `alu_flag_ov` in 1: ALU overflow.
- `alu_flag_sign` in 1: ALU result sign, 1 = negative.
- `operand0`, `operand1` out 4*DIGIT_NUM: BCD magnitudes to ALU, registered.
- `operand0_sign`, `operand1_sign` out 1: operand signs, registered.
- `operation` out 3: ALU opcode; SUM 000, SUB 001, MUL 010, DIV 011, EXP 100.
- `disp_value` out 4*DIGIT_NUM, `disp_sign` out 1: value to display.
- `busy` out 1: high in EXEC; keys are dropped.
- `error` out 1: high in ERROR.

## Operation
- States: ENTER_A, ENTER_B, EXEC, SHOW, ERROR. Reset state is ENTER_A.
- Reset values: operands 0, signs 0, `operation` = SUM, digit counters 0, result register 0, `busy` = 0, `error` = 0.
- **Digit entry** (ENTER_A → operand0, ENTER_B → operand1):
  - If the counter is below DIGIT_NUM, shift the operand left 4 bits, insert the digit in the LSD, and increment the counter.
  - If the counter equals DIGIT_NUM, ignore the key and change nothing.
  - A leading 0 with counter 0 leaves the value 0 and does not increment.
- **ENTER_A**:
  - SIGN toggles `operand0_sign`.
  - An operator key latches `operation`, clears operand1, its sign and its counter, then moves to ENTER_B.
  - EQUALS is ignored.
- **ENTER_B**:
  - SIGN toggles `operand1_sign`.
  - An operator key replaces `operation` only while counter B is 0; otherwise it is ignored.
  - EQUALS moves to EXEC.
- **EXEC**: lasts exactly one cycle. Operands and opcode are held stable, so the ALU output has settled by the EXEC edge. On that edge:
  - capture `alu_result` and `alu_flag_sign` into the result register;
  - force the sign to 0 if the magnitude is 0;
  - go to ERROR if `alu_flag_ov` = 1, else go to SHOW.
- **SHOW**:
  - A digit clears operand0 and its sign, loads the digit, and moves to ENTER_A.
  - An operator copies the result and sign into operand0 (chaining), sets counter A to DIGIT_NUM, latches `operation`, clears operand1, and moves to ENTER_B.
  - SIGN toggles the result sign unless the magnitude is 0.
  - EQUALS is ignored.
- **ERROR**: all keys except CLEAR are ignored.
- **CLEAR**, in any state except EXEC: full return to reset values.
- **Display**:
  - ENTER_A shows operand0 and its sign.
  - ENTER_B shows operand1 and its sign.
  - EXEC and SHOW show the result register.
  - ERROR shows 0 with sign 0.
- MUL, DIV and EXP are dispatched unchanged. The correctness of their result is owned by the ALU.

## Timing
- Keys are sampled only when `key_valid` = 1 on the clock edge. Every effect is visible on the following cycle.
- From EQUALS sampled to `disp_value` showing the result: 2 edges (→EXEC, then capture).
- `busy` is high for exactly one cycle per EQUALS. A `key_valid` pulse during EXEC is lost, CLEAR included.
- `reset` asserted mid-operation returns every output to its reset value immediately, without waiting for a clock edge.
- Back-to-back keys on consecutive cycles are all accepted, except during EXEC.

## Structure
- Shared package `calc_pkg`:
  - key code constants;
  - ALU opcodes (SUM..EXP), which the ALU must use as well;
  - state encoding;
  - default DIGIT_NUM.
- One sub-module: `bcd_entry_reg`. It is a per-operand shift register with digit counter, sign toggle, clear and parallel load, instantiated twice.

## Test plan
- **Addition.** Keys 1,2,3,SUM,4,5,EQUALS → `operand0` = 0x123, `operand1` = 0x45, `operation` = 000. `busy` is high 1 cycle. Display = 0x168 with sign 0.
- **Subtraction with negative result.** Keys 5,SUB,8,EQUALS → display 0x3 with sign 1. Then SIGN → sign 0.
- **Digit-count limit.** 9 consecutive digit keys 1..9 with DIGIT_NUM = 8 → `operand0` = 0x12345678; the ninth digit is ignored.
- **Overflow.** 99999999 SUM 1 EQUALS → `error` = 1, display 0. Digits are then ignored. CLEAR → ENTER_A with all outputs 0.
- **Chaining.** 7 SUM 3 EQUALS (display 0x10), then SUB, 4, EQUALS → `operand0` = 0x10 and display 0x6.
- **Key loss and async reset.** A `key_valid` pulse during EXEC is dropped. `reset` pulsed mid-entry, between clock edges, zeroes the outputs asynchronously. Code 20 is ignored in every state.
